// File: rtl/wb_arbiter.sv
// Writeback arbiter: one-entry holding register per functional unit, drained
// round-robin onto a single registered register-file writeback bus.
module wb_arbiter #(
  parameter int NREQ   = 4,
  parameter int REG_W  = 5,
  parameter int DATA_W = 32,
  parameter int SRC_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    flush,
  input  logic                    freeze,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*REG_W-1:0]   req_rd,
  input  logic [NREQ*DATA_W-1:0]  req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    wb_en,
  output logic [REG_W-1:0]        wb_rd,
  output logic [DATA_W-1:0]       wb_data,
  output logic [SRC_W-1:0]        wb_src
);

  logic [NREQ-1:0]   hold_v;
  logic [REG_W-1:0]  hold_rd   [NREQ];
  logic [DATA_W-1:0] hold_data [NREQ];
  logic [SRC_W-1:0]  rr_ptr;

  logic [NREQ-1:0]   elig;
  logic [NREQ-1:0]   grant;
  logic [SRC_W-1:0]  grant_idx;
  logic              grant_found;

  assign elig = (!freeze && !flush) ? hold_v : '0;

  // Circular first-set search over the eligible holds, starting at rr_ptr.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!grant_found && elig[idx]) begin
        grant_found = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = SRC_W'(idx);
      end else begin
        grant_found = grant_found;
      end
    end
  end

  // A slot draining this cycle can be refilled in the same cycle.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = !RST && !flush && (!hold_v[i] || grant[i]);
    end
  end

  // Holding registers, round-robin pointer and the registered writeback bus.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_v  <= '0;
      rr_ptr  <= '0;
      wb_en   <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
      wb_src  <= '0;
      for (int i = 0; i < NREQ; i++) begin
        hold_rd[i]   <= '0;
        hold_data[i] <= '0;
      end
    end else begin
      wb_en <= grant_found;
      if (grant_found) begin
        wb_rd   <= hold_rd[grant_idx];
        wb_data <= hold_data[grant_idx];
        wb_src  <= grant_idx;
        if (grant_idx == SRC_W'(NREQ - 1)) begin
          rr_ptr <= '0;
        end else begin
          rr_ptr <= grant_idx + SRC_W'(1);
        end
      end else begin
        rr_ptr <= rr_ptr;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (flush) begin
          hold_v[i] <= 1'b0;
        end else if (req_valid[i] && req_ready[i]) begin
          // x0 results are consumed but never written back.
          hold_v[i]    <= (req_rd[i*REG_W +: REG_W] != '0);
          hold_rd[i]   <= req_rd[i*REG_W +: REG_W];
          hold_data[i] <= req_data[i*DATA_W +: DATA_W];
        end else if (grant[i]) begin
          hold_v[i] <= 1'b0;
        end else begin
          hold_v[i] <= hold_v[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a slot-level reference model predicts each
// cycle's writeback bus and ready vector; a monitor pops and compares.
module tb_wb_arbiter;

  localparam int NREQ = 4;
  localparam int REG_W = 5;
  localparam int DATA_W = 32;
  localparam int SRC_W = 2;

  typedef struct packed {
    logic              en;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
    logic [SRC_W-1:0]  src;
  } exp_t;

  logic                   CLK;
  logic                   RST;
  logic                   flush;
  logic                   freeze;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*REG_W-1:0]  req_rd;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   wb_en;
  logic [REG_W-1:0]       wb_rd;
  logic [DATA_W-1:0]      wb_data;
  logic [SRC_W-1:0]       wb_src;

  wb_arbiter #(.NREQ(NREQ), .REG_W(REG_W), .DATA_W(DATA_W), .SRC_W(SRC_W)) dut (
    .CLK(CLK), .RST(RST), .flush(flush), .freeze(freeze),
    .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
    .req_ready(req_ready), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_src(wb_src)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;
  exp_t exp_q[$];

  // Requester side: item offered by each unit until accepted.
  logic              p_v    [NREQ];
  logic [REG_W-1:0]  p_rd   [NREQ];
  logic [DATA_W-1:0] p_data [NREQ];
  logic rst_s, flush_s, freeze_s;
  int   drop_pct = 0;

  // Reference model: what each slot holds and whose turn it is.
  logic              m_v    [NREQ];
  logic [REG_W-1:0]  m_rd   [NREQ];
  logic [DATA_W-1:0] m_data [NREQ];
  int                m_ptr;
  exp_t              m_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic step();
    logic [NREQ-1:0] rdy;
    int g;
    exp_t e;
    @(negedge CLK);
    for (int i = 0; i < NREQ; i++) begin
      if (p_v[i] && !rst_s && ($urandom_range(0, 99) < drop_pct)) p_v[i] = 1'b0;
      req_valid[i] = p_v[i];
      req_rd[i*REG_W +: REG_W] = p_rd[i];
      req_data[i*DATA_W +: DATA_W] = p_data[i];
    end
    RST = rst_s;
    flush = flush_s;
    freeze = freeze_s;
    #1;
    g = -1;
    if (!rst_s && !flush_s && !freeze_s) begin
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (m_ptr + k) % NREQ;
        if (g < 0 && m_v[j]) g = j;
      end
    end
    for (int i = 0; i < NREQ; i++) rdy[i] = !rst_s && !flush_s && (!m_v[i] || g == i);
    chk("req_ready", 64'(req_ready), 64'(rdy));
    if (rst_s) begin
      for (int i = 0; i < NREQ; i++) m_v[i] = 1'b0;
      m_ptr = 0;
      m_last = '0;
      e = '0;
    end else begin
      if (g >= 0) begin
        m_last.rd = m_rd[g];
        m_last.data = m_data[g];
        m_last.src = SRC_W'(g);
        m_ptr = (g + 1) % NREQ;
      end
      e = m_last;
      e.en = (g >= 0);
      for (int i = 0; i < NREQ; i++) begin
        if (flush_s) m_v[i] = 1'b0;
        else if (p_v[i] && rdy[i]) begin
          m_v[i] = (p_rd[i] != '0);
          m_rd[i] = p_rd[i];
          m_data[i] = p_data[i];
        end else if (g == i) m_v[i] = 1'b0;
      end
    end
    exp_q.push_back(e);
    for (int i = 0; i < NREQ; i++) if (p_v[i] && rdy[i]) p_v[i] = 1'b0;
  endtask

  task automatic offer(input int i, input logic [REG_W-1:0] rd, input logic [DATA_W-1:0] d);
    p_v[i] = 1'b1;
    p_rd[i] = rd;
    p_data[i] = d;
  endtask

  // Monitor: compare the writeback bus after every edge with the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wb_en", 64'(wb_en), 64'(e.en));
        chk("wb_rd", 64'(wb_rd), 64'(e.rd));
        chk("wb_data", 64'(wb_data), 64'(e.data));
        chk("wb_src", 64'(wb_src), 64'(e.src));
        if (wb_en && wb_rd == '0) chk("wb_rd_x0", 64'(wb_rd), 64'd1);
      end
    end
  end

  initial begin
    int r;
    RST = 1'b1; flush = 1'b0; freeze = 1'b0;
    req_valid = '0; req_rd = '0; req_data = '0;
    rst_s = 1'b1; flush_s = 1'b0; freeze_s = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      p_v[i] = 1'b0; p_rd[i] = '0; p_data[i] = '0;
      m_v[i] = 1'b0; m_rd[i] = '0; m_data[i] = '0;
    end
    m_ptr = 0;
    m_last = '0;
    repeat (2) step();
    rst_s = 1'b0;

    // Single request from the ALU.
    offer(0, 5'd5, 32'hDEADBEEF);
    repeat (4) step();

    // All four units stream continuously.
    repeat (16) begin
      for (int i = 0; i < NREQ; i++) if (!p_v[i]) offer(i, REG_W'($urandom_range(1, 31)), $urandom);
      step();
    end
    repeat (6) step();

    // Unit 2 streams rd 1..8 back to back.
    r = 1;
    repeat (12) begin
      if (!p_v[2] && r <= 8) begin
        offer(2, REG_W'(r), 32'h1000 + 32'(r));
        r++;
      end
      step();
    end

    // Freeze with unit 1 holding rd 7.
    offer(1, 5'd7, 32'h7777_0001);
    step();
    freeze_s = 1'b1;
    repeat (3) step();
    freeze_s = 1'b0;
    repeat (3) step();

    // Flush while units 0 and 3 hold results.
    offer(0, 5'd10, 32'hA0A0_0000);
    offer(3, 5'd13, 32'hB3B3_0000);
    step();
    flush_s = 1'b1;
    step();
    flush_s = 1'b0;
    repeat (3) step();

    // x0 discard and reset with a pending hold.
    offer(0, 5'd0, 32'h0BAD_0000);
    offer(1, 5'd9, 32'h9999_0000);
    step();
    rst_s = 1'b1;
    step();
    rst_s = 1'b0;
    repeat (3) step();

    // Randomised traffic with flushes, freezes, drops and rare resets.
    drop_pct = 5;
    repeat (500) begin
      for (int i = 0; i < NREQ; i++)
        if (!p_v[i] && $urandom_range(0, 99) < 50) offer(i, REG_W'($urandom_range(0, 31)), $urandom);
      flush_s = ($urandom_range(0, 99) < 5);
      freeze_s = ($urandom_range(0, 99) < 10);
      rst_s = ($urandom_range(0, 199) == 0);
      step();
    end
    drop_pct = 0;
    rst_s = 1'b0; flush_s = 1'b0; freeze_s = 1'b0;
    for (int i = 0; i < NREQ; i++) p_v[i] = 1'b0;
    repeat (8) step();

    repeat (3) @(posedge CLK);
    #2;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
